operand_stream_bank: RTL and testbench
======================================

OPERAND_STREAM_BANK -- requirements
Module: operand_stream_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 32, element width in bits.
REQ-002 Parameter BUS_WIDTH, default 64, row width; MAX_DIM = BUS_WIDTH/DATA_WIDTH, power of two, >= 2; AW = clog2(MAX_DIM).
REQ-003 Parameter NUM_BANKS, default 2, number of operand matrices (>= 2); BW = clog2(NUM_BANKS).
REQ-004 One clock; reset is synchronous and active-low: clk_i input 1, rising-edge clock; rst_ni input 1, reset.
REQ-005 write_enable_i input 1 host row write; bank_sel_i input BW target bank; address_i input AW row index; data_i input BUS_WIDTH write data; strobe_i input MAX_DIM per-element write enable.
REQ-006 data_o output BUS_WIDTH host readback of row [bank_sel_i][address_i].
REQ-007 start_i input 1 stream request; start_addr_i input AW first row; length_i input AW row count (0 means MAX_DIM); transpose_i input 1 column mode.
REQ-008 op_valid_o output 1; op_ready_i input 1; op_data_o output NUM_BANKS*BUS_WIDTH, bank k at slice k; op_index_o output AW current row; op_last_o output 1 final beat.
REQ-009 busy_o output 1 stream active; done_o output 1 single-cycle completion pulse.

Function
REQ-010 Write: on clock with write_enable_i=1, element b of row [bank_sel_i][address_i] SHALL take data_i element b when strobe_i[b]=1; unstrobed elements retain value.
REQ-011 data_o SHALL be combinational: selected row when write_enable_i=0, all-zero when 1.
REQ-012 FSM states IDLE, STREAM, DONE; reset state IDLE.
REQ-013 IDLE: start_i=1 SHALL latch start_addr_i, length_i, transpose_i, clear beat counter, enter STREAM next cycle; start_i ignored in STREAM and DONE.
REQ-014 STREAM: op_valid_o=1, busy_o=1; op_data_o/op_index_o combinational from pointer and current register contents.
REQ-015 Beat completes when op_valid_o and op_ready_i both 1; pointer SHALL advance by 1 modulo MAX_DIM (MAX_DIM-1 wraps to 0); op_valid_o held with stable pointer while op_ready_i=0.
REQ-016 op_last_o=1 during beat number length-1; its completion SHALL enter DONE.
REQ-017 DONE: done_o=1, busy_o=1, op_valid_o=0 for exactly one cycle, then IDLE.
REQ-018 Host writes during STREAM SHALL be accepted; new contents appear on op_data_o the following cycle.
REQ-019 length 0 streams MAX_DIM beats; length 1 streams one beat with op_last_o=1.

Reset
REQ-020 rst_ni=0 at a clock edge SHALL clear all bank registers, pointer, counter, latched mode; FSM to IDLE, including mid-stream.
REQ-021 After reset all outputs SHALL be 0 (data_o reflects zeroed registers).

Configuration
REQ-022 Macro OPERAND_TRANSPOSE_EN defined: with latched transpose=1, bank k slice element j SHALL be element [ptr] of row j of bank k (column ptr).
REQ-023 Macro undefined: transpose_i ignored, row mode only, no transpose logic synthesised.

Structure
REQ-024 Package operand_pkg SHALL hold FSM state enum and MAX_DIM/AW derivation constants/functions.
REQ-025 Sub-module operand_row_bank SHALL implement one bank: strobed write port, host read port, stream read port; instantiated NUM_BANKS times.

Verification (DATA_WIDTH=32, BUS_WIDTH=128, MAX_DIM=4)
REQ-026 Write bank0 row2 data 0x4_3_2_1 (elements) strobe 4'b0101, prior 0xA_B_C_D -> data_o = 0xA_3_C_1.
REQ-027 start_addr=3, length=3, op_ready_i=1 -> op_index_o 3,0,1; op_last_o on index 1; done_o one cycle after.
REQ-028 length=0, op_ready_i toggled 1,0,1,... -> 4 beats, pointer frozen on ready=0 cycles, no beat duplicated or dropped.
REQ-029 Bank0 rows r hold elements 4r+e; transpose=1, start_addr=1 with OPERAND_TRANSPOSE_EN -> first bank0 slice = {13,9,5,1}; without macro -> row 1.
REQ-030 rst_ni=0 during beat 2 of 4 -> next cycle op_valid_o=0, busy_o=0, all rows read zero; start_i ignored while busy.

Source files
------------

// File: rtl/operand_pkg.sv
// Shared types and size helpers for the operand stream bank.
package operand_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_e;

    function automatic int calc_max_dim(input int bus_width, input int data_width);
        return bus_width / data_width;
    endfunction

    // Index width for n entries; never narrower than one bit.
    function automatic int calc_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/operand_stream_bank_if.sv
// Operand stream handshake: master presents one row/column of every bank per beat.
interface operand_stream_bank_if #(
    parameter int NUM_BANKS = 2,
    parameter int BUS_WIDTH = 64,
    parameter int AW        = 1
);
    logic                           op_valid;
    logic                           op_ready;
    logic [NUM_BANKS*BUS_WIDTH-1:0] op_data;
    logic [AW-1:0]                  op_index;
    logic                           op_last;

    modport master (output op_valid, op_data, op_index, op_last, input op_ready);
    modport slave  (input op_valid, op_data, op_index, op_last, output op_ready);
endinterface

// File: rtl/operand_row_bank.sv
// One MAX_DIM x MAX_DIM operand matrix: strobed row write, host row read, stream read.
// Column read for the stream port exists only when OPERAND_TRANSPOSE_EN is defined.
module operand_row_bank
    import operand_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  BUS_WIDTH  = 64,
    localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int AW         = calc_width(MAX_DIM)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 write_enable_i,
    input  logic [AW-1:0]        address_i,
    input  logic [BUS_WIDTH-1:0] data_i,
    input  logic [MAX_DIM-1:0]   strobe_i,
    output logic [BUS_WIDTH-1:0] rd_data_o,
    input  logic [AW-1:0]        stream_ptr_i,
`ifdef OPERAND_TRANSPOSE_EN
    input  logic                 transpose_i,
`endif
    output logic [BUS_WIDTH-1:0] stream_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [MAX_DIM][MAX_DIM];

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int r = 0; r < MAX_DIM; r++) begin
                for (int e = 0; e < MAX_DIM; e++) begin
                    mem_q[r][e] <= '0;
                end
            end
        end else if (write_enable_i) begin
            for (int e = 0; e < MAX_DIM; e++) begin
                if (strobe_i[e]) begin
                    mem_q[address_i][e] <= data_i[e*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    always_comb begin
        rd_data_o     = '0;
        stream_data_o = '0;
        for (int e = 0; e < MAX_DIM; e++) begin
            rd_data_o[e*DATA_WIDTH +: DATA_WIDTH] = mem_q[address_i][e];
`ifdef OPERAND_TRANSPOSE_EN
            stream_data_o[e*DATA_WIDTH +: DATA_WIDTH] =
                transpose_i ? mem_q[e][stream_ptr_i] : mem_q[stream_ptr_i][e];
`else
            stream_data_o[e*DATA_WIDTH +: DATA_WIDTH] = mem_q[stream_ptr_i][e];
`endif
        end
    end

endmodule

// File: rtl/operand_stream_bank.sv
// NUM_BANKS operand matrices with host access and a beat-by-beat row/column stream.
// Define OPERAND_TRANSPOSE_EN to enable column (transpose) streaming.
//
// state  | meaning
// IDLE   | waiting for start_i
// STREAM | presenting one row/column of every bank per beat
// DONE   | one-cycle completion pulse, then back to IDLE
module operand_stream_bank
    import operand_pkg::*;
#(
    parameter int  DATA_WIDTH = 32,
    parameter int  BUS_WIDTH  = 64,
    parameter int  NUM_BANKS  = 2,
    localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
    localparam int AW         = calc_width(MAX_DIM),
    localparam int BW         = calc_width(NUM_BANKS)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 write_enable_i,
    input  logic [BW-1:0]        bank_sel_i,
    input  logic [AW-1:0]        address_i,
    input  logic [BUS_WIDTH-1:0] data_i,
    input  logic [MAX_DIM-1:0]   strobe_i,
    output logic [BUS_WIDTH-1:0] data_o,
    input  logic                 start_i,
    input  logic [AW-1:0]        start_addr_i,
    input  logic [AW-1:0]        length_i,
    input  logic                 transpose_i,
    operand_stream_bank_if.master op_if,
    output logic                 busy_o,
    output logic                 done_o
);

    stream_state_e state_q, state_d;
    logic [AW-1:0] ptr_q, cnt_q, len_q;
    logic          load, advance, beat_last, op_valid, op_last;
    logic [NUM_BANKS-1:0]           bank_we;
    logic [BUS_WIDTH-1:0]           rd_rows [NUM_BANKS];
    logic [NUM_BANKS*BUS_WIDTH-1:0] op_data_flat;

`ifdef OPERAND_TRANSPOSE_EN
    logic trans_q;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            trans_q <= 1'b0;
        end else if (load) begin
            trans_q <= transpose_i;
        end
    end
`else
    logic unused_transpose;
    assign unused_transpose = transpose_i;
`endif

    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        assign bank_we[k] = write_enable_i && (bank_sel_i == BW'(k));

        operand_row_bank #(
            .DATA_WIDTH(DATA_WIDTH),
            .BUS_WIDTH (BUS_WIDTH)
        ) u_bank (
            .clk_i         (clk_i),
            .rst_ni        (rst_ni),
            .write_enable_i(bank_we[k]),
            .address_i     (address_i),
            .data_i        (data_i),
            .strobe_i      (strobe_i),
            .rd_data_o     (rd_rows[k]),
            .stream_ptr_i  (ptr_q),
`ifdef OPERAND_TRANSPOSE_EN
            .transpose_i   (trans_q),
`endif
            .stream_data_o (op_data_flat[k*BUS_WIDTH +: BUS_WIDTH])
        );
    end

    // Readback is blanked while a write is being presented.
    always_comb begin
        data_o = '0;
        for (int k = 0; k < NUM_BANKS; k++) begin
            if (!write_enable_i && (bank_sel_i == BW'(k))) begin
                data_o = rd_rows[k];
            end
        end
    end

    // length 0 wraps to MAX_DIM-1, giving a full MAX_DIM-beat stream.
    assign beat_last = (cnt_q == len_q - AW'(1));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load     = 1'b0;
        advance  = 1'b0;
        op_valid = 1'b0;
        op_last  = 1'b0;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    load    = 1'b1;
                    state_d = ST_STREAM;
                end
            end
            ST_STREAM: begin
                op_valid = 1'b1;
                busy_o   = 1'b1;
                op_last  = beat_last;
                if (op_if.op_ready) begin
                    advance = 1'b1;
                    if (beat_last) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                busy_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
        end else if (load) begin
            ptr_q <= start_addr_i;
            len_q <= length_i;
            cnt_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_q + AW'(1);
            cnt_q <= cnt_q + AW'(1);
        end
    end

    assign op_if.op_valid = op_valid;
    assign op_if.op_last  = op_last;
    assign op_if.op_index = ptr_q;
    assign op_if.op_data  = op_data_flat;

endmodule

// File: tb/tb_operand_stream_bank.sv
// Randomized bench for operand_stream_bank against a queue-based reference model.
module tb_operand_stream_bank;

    localparam int DW   = 32;
    localparam int BUSW = 128;
    localparam int NB   = 2;
    localparam int MD   = 4;
    localparam int AW   = 2;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              write_enable_i;
    logic              bank_sel_i;
    logic [AW-1:0]     address_i;
    logic [BUSW-1:0]   data_i;
    logic [MD-1:0]     strobe_i;
    logic [BUSW-1:0]   data_o;
    logic              start_i;
    logic [AW-1:0]     start_addr_i;
    logic [AW-1:0]     length_i;
    logic              transpose_i;
    logic              busy_o;
    logic              done_o;

    always #5 clk_i = ~clk_i;

    operand_stream_bank_if #(.NUM_BANKS(NB), .BUS_WIDTH(BUSW), .AW(AW)) op_if ();

    operand_stream_bank #(.DATA_WIDTH(DW), .BUS_WIDTH(BUSW), .NUM_BANKS(NB)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .write_enable_i(write_enable_i),
        .bank_sel_i    (bank_sel_i),
        .address_i     (address_i),
        .data_i        (data_i),
        .strobe_i      (strobe_i),
        .data_o        (data_o),
        .start_i       (start_i),
        .start_addr_i  (start_addr_i),
        .length_i      (length_i),
        .transpose_i   (transpose_i),
        .op_if         (op_if),
        .busy_o        (busy_o),
        .done_o        (done_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: matrix contents plus a queue of row indices still to be streamed.
    logic [DW-1:0] m_mem [NB][MD][MD];
    int            exp_q[$];
    bit            m_done;
    bit            m_trans;
    bit            chk_en = 1'b0;

    function automatic logic [NB*BUSW-1:0] exp_stream(int p);
        logic [NB*BUSW-1:0] r;
        r = '0;
        for (int k = 0; k < NB; k++) begin
            for (int j = 0; j < MD; j++) begin
                if (m_trans) r[(k*MD+j)*DW +: DW] = m_mem[k][j][p];
                else         r[(k*MD+j)*DW +: DW] = m_mem[k][p][j];
            end
        end
        return r;
    endfunction

    function automatic logic [BUSW-1:0] exp_row(int k, int a);
        logic [BUSW-1:0] r;
        for (int j = 0; j < MD; j++) r[j*DW +: DW] = m_mem[k][a][j];
        return r;
    endfunction

    always @(posedge clk_i) begin
        bit idle;
        bit nd;
        int n;
        if (!rst_ni) begin
            for (int k = 0; k < NB; k++)
                for (int r = 0; r < MD; r++)
                    for (int e = 0; e < MD; e++) m_mem[k][r][e] = '0;
            exp_q.delete();
            m_done  = 1'b0;
            m_trans = 1'b0;
        end else begin
            idle = (exp_q.size() == 0) && !m_done;
            nd   = 1'b0;
            if (exp_q.size() != 0 && op_if.op_ready) begin
                void'(exp_q.pop_front());
                if (exp_q.size() == 0) nd = 1'b1;
            end
            if (idle && start_i) begin
                n = (length_i == 0) ? MD : int'(length_i);
                for (int i = 0; i < n; i++) exp_q.push_back((int'(start_addr_i) + i) % MD);
`ifdef OPERAND_TRANSPOSE_EN
                m_trans = transpose_i;
`endif
            end
            if (write_enable_i)
                for (int e = 0; e < MD; e++)
                    if (strobe_i[e]) m_mem[bank_sel_i][address_i][e] = data_i[e*DW +: DW];
            m_done = nd;
        end
    end

    always @(negedge clk_i) begin
        bit v;
        if (chk_en) begin
            v = (exp_q.size() != 0);
            check("op_valid", op_if.op_valid, v);
            check("op_last", op_if.op_last, v && exp_q.size() == 1);
            check("busy", busy_o, v || m_done);
            check("done", done_o, m_done);
            check("data_o", data_o,
                  write_enable_i ? '0 : exp_row(int'(bank_sel_i), int'(address_i)));
            if (v) begin
                check("op_index", op_if.op_index, exp_q[0]);
                check("op_data", op_if.op_data, exp_stream(exp_q[0]));
            end
        end
    end

    initial begin
        int seen[$];
        int last_at, done_at, done_cnt, beats;
        logic [BUSW-1:0] exp_slice;

        rst_ni = 1'b0; write_enable_i = 1'b0; bank_sel_i = 1'b0; address_i = '0;
        data_i = '0; strobe_i = '0; start_i = 1'b0; start_addr_i = '0;
        length_i = '0; transpose_i = 1'b0; op_if.op_ready = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk_en = 1'b1;
        check("rst_op_valid", op_if.op_valid, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_op_index", op_if.op_index, 0);
        check("rst_op_data", op_if.op_data, 0);
        check("rst_data_o", data_o, 0);

        // Strobed write over a known prior row.
        #1 rst_ni = 1'b1;
        write_enable_i = 1'b1; bank_sel_i = 1'b0; address_i = 2'd2;
        data_i = {32'hA, 32'hB, 32'hC, 32'hD}; strobe_i = 4'hF;
        @(negedge clk_i); #1;
        data_i = {32'h4, 32'h3, 32'h2, 32'h1}; strobe_i = 4'b0101;
        @(negedge clk_i); #1;
        write_enable_i = 1'b0;
        @(negedge clk_i);
        check("strobe_write_row", data_o, {32'hA, 32'h3, 32'hC, 32'h1});

        // Wrapping stream of three beats from row 3.
        #1 start_i = 1'b1; start_addr_i = 2'd3; length_i = 2'd3; op_if.op_ready = 1'b1;
        last_at = -1; done_at = -1; done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk_i);
            if (op_if.op_valid) begin
                seen.push_back(int'(op_if.op_index));
                if (op_if.op_last) last_at = seen.size() - 1;
            end
            if (done_o) begin done_at = c; done_cnt++; end
            #1 start_i = 1'b0;
        end
        check("wrap_beats", seen.size(), 3);
        check("wrap_idx0", (seen.size() > 0) ? seen[0] : -1, 3);
        check("wrap_idx1", (seen.size() > 1) ? seen[1] : -1, 0);
        check("wrap_idx2", (seen.size() > 2) ? seen[2] : -1, 1);
        check("wrap_last_pos", last_at, 2);
        check("wrap_done_cycle", done_at, 3);
        check("wrap_done_count", done_cnt, 1);

        // Full-length stream under toggling ready.
        seen.delete(); beats = 0;
        start_i = 1'b1; start_addr_i = 2'd1; length_i = 2'd0; op_if.op_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk_i);
            if (op_if.op_valid && op_if.op_ready) begin
                seen.push_back(int'(op_if.op_index));
                beats++;
            end
            #1 start_i = 1'b0;
            op_if.op_ready = ~op_if.op_ready;
        end
        check("full_len_beats", beats, 4);
        check("full_len_idx0", (seen.size() > 0) ? seen[0] : -1, 1);
        check("full_len_idx3", (seen.size() > 3) ? seen[3] : -1, 0);

        // Row-mode vs column-mode slice of bank 0.
        op_if.op_ready = 1'b0;
        for (int r = 0; r < MD; r++) begin
            write_enable_i = 1'b1; bank_sel_i = 1'b0; address_i = AW'(r); strobe_i = 4'hF;
            data_i = {32'(4*r+3), 32'(4*r+2), 32'(4*r+1), 32'(4*r)};
            @(negedge clk_i); #1;
            bank_sel_i = 1'b1;
            data_i = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk_i); #1;
        end
        write_enable_i = 1'b0;
        start_i = 1'b1; start_addr_i = 2'd1; length_i = 2'd1; transpose_i = 1'b1;
        @(negedge clk_i);
`ifdef OPERAND_TRANSPOSE_EN
        exp_slice = {32'd13, 32'd9, 32'd5, 32'd1};
`else
        exp_slice = {32'd7, 32'd6, 32'd5, 32'd4};
`endif
        check("mode_slice_bank0", op_if.op_data[BUSW-1:0], exp_slice);
        #1 start_i = 1'b0; transpose_i = 1'b0; op_if.op_ready = 1'b1;
        repeat (3) @(negedge clk_i);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            #1;
            rst_ni         = ($urandom_range(0, 299) != 0);
            write_enable_i = ($urandom_range(0, 2) == 0);
            bank_sel_i     = 1'($urandom_range(0, 1));
            address_i      = AW'($urandom_range(0, MD-1));
            data_i         = {$urandom, $urandom, $urandom, $urandom};
            strobe_i       = MD'($urandom_range(0, 15));
            start_i        = ($urandom_range(0, 3) == 0);
            start_addr_i   = AW'($urandom_range(0, MD-1));
            length_i       = AW'($urandom_range(0, MD-1));
            transpose_i    = 1'($urandom_range(0, 1));
            op_if.op_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk_i);
        end

        // Reset in the middle of a four-beat stream; a second start is ignored.
        #1 rst_ni = 1'b1; write_enable_i = 1'b0; start_i = 1'b0; op_if.op_ready = 1'b1;
        for (int c = 0; c < 10 && (exp_q.size() != 0 || m_done); c++) @(negedge clk_i);
        #1 start_i = 1'b1; start_addr_i = 2'd0; length_i = 2'd0;
        @(negedge clk_i);
        #1 start_addr_i = 2'd2; length_i = 2'd1;
        @(negedge clk_i);
        check("busy_ignores_start", op_if.op_index, 1);
        #1 rst_ni = 1'b0; start_i = 1'b0;
        @(negedge clk_i);
        check("midrst_op_valid", op_if.op_valid, 0);
        check("midrst_busy", busy_o, 0);
        #1 rst_ni = 1'b1;
        for (int i = 0; i < NB*MD; i++) begin
            bank_sel_i = 1'(i / MD); address_i = AW'(i % MD);
            @(negedge clk_i);
            check("midrst_row_zero", data_o, 0);
            #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
